// File: rtl/fir_tdm_mac_core.sv
// Time-multiplexed FIR: NUM_BANKS MAC lanes, each stepping through TPB taps per sample,
// with shadow/active coefficient banks. Define FIR_SAT_EN to saturate oFirOut instead of wrapping.

module fir_tdm_lane #(
    parameter int IN_W   = 3,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [COEF_W-1:0] coef,
    input  logic [IN_W-1:0]   samp,
    output logic [ACC_W-1:0]  acc
);
    logic signed [IN_W+COEF_W-1:0] prod;

    assign prod = $signed(coef) * $signed(samp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + ACC_W'(prod);
    end
endmodule

module fir_tdm_mac_core #(
    parameter int IN_W      = 3,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int NUM_TAPS  = 40,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 6
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic [IN_W-1:0]   iFirIn,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [ADDR_W-1:0] iAddrRam,
    input  logic [COEF_W-1:0] iWrDtRam,
    output logic [COEF_W-1:0] oRdDtRam,
    input  logic              iCoeffUpdateFlag,
    output logic              oUpdPending,
    output logic [OUT_W-1:0]  oFirOut,
    output logic              oFirValid,
    output logic              oBusy,
    output logic              oOverrun
);
    localparam int TPB = NUM_TAPS / NUM_BANKS;
    localparam int KW  = (TPB > 1) ? $clog2(TPB) : 1;
    localparam int TW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_OUT} state_t;

    state_t                                 state, state_nx;
    logic [KW-1:0]                          k;
    logic [NUM_TAPS-1:0][IN_W-1:0]          dly;
    logic [NUM_TAPS-1:0][COEF_W-1:0]        shadow, active;
    logic [NUM_BANKS-1:0][COEF_W-1:0]       lane_coef;
    logic [NUM_BANKS-1:0][IN_W-1:0]         lane_samp;
    logic [NUM_BANKS-1:0][ACC_W-1:0]        lane_acc;
    logic signed [ACC_W-1:0]                total, total_c;
    logic [OUT_W-1:0]                       out_c;
    logic                                   start, copy, acc_clr, acc_en, addr_ok, k_last;

    assign start   = iEnSample600k && (state == S_IDLE);
    assign copy    = oUpdPending && (state == S_IDLE);
    assign oBusy   = (state != S_IDLE);
    assign addr_ok = (iAddrRam < ADDR_W'(NUM_TAPS));
    assign k_last  = (k == KW'(TPB - 1));

    always_comb begin
        state_nx = state;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state)
            S_IDLE: if (iEnSample600k) begin state_nx = S_MAC; acc_clr = 1'b1; end
            S_MAC: begin
                acc_en = 1'b1;
                if (k_last) state_nx = S_SUM;
            end
            S_SUM:   state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Lane b owns taps b*TPB .. b*TPB+TPB-1; k walks through them in lockstep.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_lane_sel
        logic [TW-1:0] idx;
        assign idx          = TW'(b * TPB) + TW'(k);
        assign lane_coef[b] = active[idx];
        assign lane_samp[b] = dly[idx];
    end

    fir_tdm_lane #(.IN_W(IN_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane [NUM_BANKS-1:0] (
        .clk   (iClk12M),
        .rst_n (iRsn),
        .clr   (acc_clr),
        .en    (acc_en),
        .coef  (lane_coef),
        .samp  (lane_samp),
        .acc   (lane_acc)
    );

    always_comb begin
        total_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) total_c = total_c + $signed(lane_acc[b]);
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    always_comb begin
        if (total > SAT_HI)      out_c = {1'b0, {(OUT_W-1){1'b1}}};
        else if (total < SAT_LO) out_c = {1'b1, {(OUT_W-1){1'b0}}};
        else                     out_c = total[OUT_W-1:0];
    end
`else
    assign out_c = total[OUT_W-1:0];
`endif

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state       <= S_IDLE;
            k           <= '0;
            dly         <= '0;
            total       <= '0;
            oFirOut     <= '0;
            oFirValid   <= 1'b0;
            oOverrun    <= 1'b0;
        end else begin
            state     <= state_nx;
            oFirValid <= 1'b0;
            if (start) begin
                dly <= {dly[NUM_TAPS-2:0], iFirIn};
                k   <= '0;
            end else if (state == S_MAC && !k_last) begin
                k <= k + 1'b1;
            end
            if (iEnSample600k && oBusy) oOverrun <= 1'b1;
            if (state == S_SUM) total <= total_c;
            if (state == S_OUT) begin
                oFirOut   <= out_c;
                oFirValid <= 1'b1;
            end
        end
    end

    // Copy samples shadow before this edge's write, so a same-edge write lands only in shadow.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            shadow      <= '0;
            active      <= '0;
            oRdDtRam    <= '0;
            oUpdPending <= 1'b0;
        end else begin
            if (!iCsnRam && !iWrnRam && addr_ok) shadow[TW'(iAddrRam)] <= iWrDtRam;
            if (!iCsnRam && iWrnRam) oRdDtRam <= addr_ok ? shadow[TW'(iAddrRam)] : '0;
            if (copy) begin
                active      <= shadow;
                oUpdPending <= 1'b0;
            end else if (iCoeffUpdateFlag) begin
                oUpdPending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_tdm_mac_core.sv
// Directed bench for fir_tdm_mac_core: impulse, latency, shadow isolation, overrun,
// wrap/saturation (FIR_SAT_EN) and mid-sample reset.

module tb_fir_tdm_mac_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strb = 1'b0;
    logic [2:0]  fir_in = '0;
    logic        csn = 1'b1;
    logic        wrn = 1'b1;
    logic [5:0]  addr = '0;
    logic [15:0] wdat = '0;
    logic [15:0] rdat;
    logic        flag = 1'b0;
    logic        pend;
    logic [15:0] fout;
    logic        fvld;
    logic        busy;
    logic        ovr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_tdm_mac_core dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iEnSample600k    (strb),
        .iFirIn           (fir_in),
        .iCsnRam          (csn),
        .iWrnRam          (wrn),
        .iAddrRam         (addr),
        .iWrDtRam         (wdat),
        .oRdDtRam         (rdat),
        .iCoeffUpdateFlag (flag),
        .oUpdPending      (pend),
        .oFirOut          (fout),
        .oFirValid        (fvld),
        .oBusy            (busy),
        .oOverrun         (ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input logic [15:0] d);
        csn = 1'b0; wrn = 1'b0; addr = 6'(a); wdat = d;
        tick();
        csn = 1'b1; wrn = 1'b1;
    endtask

    task automatic read_coef(input int a, output logic [15:0] d);
        csn = 1'b0; wrn = 1'b1; addr = 6'(a);
        tick();
        csn = 1'b1;
        d = rdat;
    endtask

    task automatic pulse_flag();
        flag = 1'b1;
        tick();
        flag = 1'b0;
    endtask

    task automatic start_sample(input logic [2:0] x);
        strb = 1'b1; fir_in = x;
        tick();
        strb = 1'b0; fir_in = '0;
    endtask

    task automatic wait_valid(output logic [15:0] y, output int lat);
        lat = 0;
        while (fvld !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        y = fout;
    endtask

    task automatic send(input logic [2:0] x, output logic [15:0] y);
        int lat;
        start_sample(x);
        wait_valid(y, lat);
        if (lat >= 40) check("valid_timeout", 32'(lat), 32'd12);
    endtask

    initial begin
        logic [15:0] y, rd;
        int lat, busy_cnt;

        repeat (2) tick();
        check("rst_out", 32'(fout), 0);
        check("rst_vld", 32'(fvld), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ovr", 32'(ovr), 0);
        check("post_rst_pend", 32'(pend), 0);
        check("post_rst_rd", 32'(rdat), 0);

        // Impulse: coeff[k] = k+1
        for (int i = 0; i < 40; i++) write_coef(i, 16'(i + 1));
        read_coef(0, rd);  check("rd_addr0", 32'(rd), 32'd1);
        read_coef(39, rd); check("rd_addr39", 32'(rd), 32'd40);
        read_coef(45, rd); check("rd_oob", 32'(rd), 0);
        pulse_flag();
        check("pend_set", 32'(pend), 1);
        tick();
        check("pend_clr", 32'(pend), 0);

        start_sample(3'd1);
        busy_cnt = 0; lat = 0;
        while (fvld !== 1'b1 && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check("lat", 32'(lat), 32'd12);
        check("busy_cycles", 32'(busy_cnt), 32'd12);
        check("imp_0", 32'(fout), 32'd1);
        tick();
        check("vld_width", 32'(fvld), 0);
        for (int n = 1; n < 40; n++) begin
            send(3'd0, y);
            check($sformatf("imp_%0d", n), 32'(y), 32'(n + 1));
        end
        send(3'd0, y);
        check("imp_flushed", 32'(y), 0);

        // Shadow isolation
        for (int i = 0; i < 40; i++) write_coef(i, 16'd5);
        send(3'd1, y);
        check("iso_old0", 32'(y), 32'd1);
        start_sample(3'd0);
        repeat (3) tick();
        pulse_flag();
        check("pend_mid_mac", 32'(pend), 1);
        wait_valid(y, lat);
        check("iso_old1", 32'(y), 32'd2);
        check("pend_at_idle", 32'(pend), 1);
        tick();
        check("pend_after_copy", 32'(pend), 0);
        send(3'd0, y);
        check("iso_new", 32'(y), 32'd5);

        // Overrun: second strobe five cycles after the first
        start_sample(3'd0);
        repeat (4) tick();
        check("ovr_before", 32'(ovr), 0);
        start_sample(3'd1);
        check("ovr_set", 32'(ovr), 1);
        wait_valid(y, lat);
        check("ovr_lat", 32'(lat), 32'd7);
        check("ovr_out", 32'(y), 32'd5);
        send(3'd0, y);
        check("ovr_after", 32'(y), 32'd5);
        check("ovr_sticky", 32'(ovr), 1);

        // Wrap / saturation
        for (int i = 0; i < 40; i++) write_coef(i, 16'h7FFF);
        pulse_flag();
        tick();
        for (int n = 0; n < 40; n++) send(3'd3, y);
`ifdef FIR_SAT_EN
        check("sat_pos", 32'(y), 32'h7FFF);
`else
        check("wrap_pos", 32'(y), 32'hFF88);
`endif
        for (int n = 0; n < 40; n++) send(3'b100, y);
`ifdef FIR_SAT_EN
        check("sat_neg", 32'(y), 32'h8000);
`else
        check("wrap_neg", 32'(y), 32'h00A0);
`endif

        // Reset during MAC k=4
        read_coef(1, rd);
        check("rd_before_rst", 32'(rd), 32'h7FFF);
        start_sample(3'd1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(fout), 0);
        check("midrst_vld", 32'(fvld), 0);
        check("midrst_rd", 32'(rdat), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ovr", 32'(ovr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_sample(3'd1);
        wait_valid(y, lat);
        check("rst_imp_lat", 32'(lat), 32'd12);
        check("rst_imp_out", 32'(y), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
